// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM and MEM/WB registers, data-memory handshake FSM, store lane
// steering and load extension. Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_alu_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [2:0]  ex_f3_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic        ex_wb_reg_wr_i,
  output logic [4:0]  exmem_rd_o,
  output logic [31:0] exmem_alu_o,
  output logic        exmem_wb_reg_wr_o,
  output logic [4:0]  memwb_rd_o,
  output logic [31:0] memwb_wdata_o,
  output logic        memwb_wb_reg_wr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  state_t state_q, state_d;

  logic        xm_valid_q, xm_mem_rd_q, xm_mem_wr_q, xm_wb_q;
  logic [31:0] xm_alu_q, xm_wdata_q;
  logic [4:0]  xm_rd_q;
  logic [2:0]  xm_f3_q;

  logic [4:0]  mw_rd_q;
  logic [31:0] mw_wdata_q;
  logic        mw_wb_q;

  logic        ex_issue, xm_mem, trap;
  logic [1:0]  a_lo;
  logic [31:0] lane, load_data, st_data;
  logic [3:0]  st_be;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
  endfunction

  assign xm_mem = xm_valid_q && (xm_mem_rd_q || xm_mem_wr_q);

`ifdef MEM_MISALIGN_TRAP_EN
  assign ex_issue = ex_valid_i && (ex_mem_rd_i || ex_mem_wr_i) &&
                    !is_misaligned(ex_f3_i[1:0], ex_alu_i[1:0]);
  assign trap     = xm_mem && is_misaligned(xm_f3_q[1:0], xm_alu_q[1:0]);
  assign a_lo     = xm_alu_q[1:0];
`else
  assign ex_issue = ex_valid_i && (ex_mem_rd_i || ex_mem_wr_i);
  assign trap     = 1'b0;
  // Misaligned accesses are silently rounded down to their natural alignment.
  always_comb begin
    a_lo = xm_alu_q[1:0];
    if (xm_f3_q[1:0] == 2'b10)      a_lo = 2'b00;
    else if (xm_f3_q[1:0] == 2'b01) a_lo = {xm_alu_q[1], 1'b0};
  end
`endif

  assign misalign_o = trap;
  assign stall_o    = (state_q == S_ACCESS) && !dmem_ack_i;

  always_comb begin
    state_d = state_q;
    if (!stall_o) state_d = ex_issue ? S_ACCESS : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || (!stall_o && !ex_valid_i)) begin
      xm_valid_q  <= 1'b0;
      xm_alu_q    <= '0;
      xm_wdata_q  <= '0;
      xm_rd_q     <= '0;
      xm_f3_q     <= '0;
      xm_mem_rd_q <= 1'b0;
      xm_mem_wr_q <= 1'b0;
      xm_wb_q     <= 1'b0;
    end else if (!stall_o) begin
      xm_valid_q  <= 1'b1;
      xm_alu_q    <= ex_alu_i;
      xm_wdata_q  <= ex_wdata_i;
      xm_rd_q     <= ex_rd_i;
      xm_f3_q     <= ex_f3_i;
      xm_mem_rd_q <= ex_mem_rd_i;
      xm_mem_wr_q <= ex_mem_wr_i;
      xm_wb_q     <= ex_wb_reg_wr_i;
    end
  end

  always_comb begin
    st_data = xm_wdata_q;
    st_be   = 4'b0000;
    case (xm_f3_q[1:0])
      2'b00: begin st_data = {4{xm_wdata_q[7:0]}};  st_be = 4'b0001 << a_lo; end
      2'b01: begin st_data = {2{xm_wdata_q[15:0]}}; st_be = 4'b0011 << {a_lo[1], 1'b0}; end
      2'b10: st_be = 4'b1111;
      default: ;
    endcase
  end

  assign lane = dmem_rdata_i >> {a_lo, 3'b000};

  always_comb begin
    load_data = '0;
    case (xm_f3_q)
      3'b000: load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001: load_data = {{16{lane[15]}}, lane[15:0]};
      3'b010: load_data = dmem_rdata_i;
      3'b100: load_data = {24'd0, lane[7:0]};
      3'b101: load_data = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || stall_o) begin
      mw_rd_q    <= '0;
      mw_wdata_q <= '0;
      mw_wb_q    <= 1'b0;
    end else begin
      mw_rd_q    <= xm_rd_q;
      mw_wdata_q <= (xm_valid_q && xm_mem_rd_q) ? load_data : xm_alu_q;
      mw_wb_q    <= xm_valid_q && xm_wb_q && !xm_mem_wr_q && !trap;
    end
  end

  assign dmem_req_o   = (state_q == S_ACCESS);
  assign dmem_we_o    = dmem_req_o && xm_mem_wr_q;
  assign dmem_addr_o  = dmem_req_o ? {xm_alu_q[31:2], 2'b00} : 32'd0;
  assign dmem_wdata_o = dmem_we_o ? st_data : 32'd0;
  assign dmem_be_o    = dmem_req_o ? st_be : 4'b0000;

  // A load's ALU value is its address, never the rd result, so it is not forwardable.
  assign exmem_rd_o        = xm_rd_q;
  assign exmem_alu_o       = xm_alu_q;
  assign exmem_wb_reg_wr_o = xm_valid_q && xm_wb_q && !xm_mem_rd_q && !xm_mem_wr_q;
  assign memwb_rd_o        = mw_rd_q;
  assign memwb_wdata_o     = mw_wdata_q;
  assign memwb_wb_reg_wr_o = mw_wb_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1 (rising-edge clock); rst in 1 (reset: rst, synchronous, active-high).
REQ-002 SHALL have EX-side inputs: ex_valid_i 1; ex_alu_i 32 (ALU result / address); ex_wdata_i 32 (store data, forwarded operand 2); ex_rd_i 5; ex_f3_i 3 (load/store width); ex_mem_rd_i 1; ex_mem_wr_i 1; ex_wb_reg_wr_i 1.
REQ-003 SHALL have forwarding outputs to EX: exmem_rd_o 5, exmem_alu_o 32, exmem_wb_reg_wr_o 1; memwb_rd_o 5, memwb_wdata_o 32, memwb_wb_reg_wr_o 1.
REQ-004 SHALL have data-memory port: dmem_req_o 1, dmem_we_o 1, dmem_addr_o 32, dmem_wdata_o 32, dmem_be_o 4 (out); dmem_ack_i 1, dmem_rdata_i 32 (in).
REQ-005 SHALL have stall_o out 1 (freeze upstream stages) and misalign_o out 1 (misaligned-access pulse).

Function
REQ-006 EX/MEM register SHALL capture all ex_* inputs on a clock edge when stall_o=0; it SHALL hold when stall_o=1; ex_valid_i=0 SHALL load a bubble (no memory op, no write).
REQ-007 FSM states: IDLE, ACCESS. IDLE->ACCESS when EX/MEM holds a valid load/store; ACCESS->IDLE on dmem_ack_i=1 (unless a new memory op is captured that same edge: stay ACCESS).
REQ-008 dmem_req_o SHALL be 1 in ACCESS; addr/we/wdata/be SHALL stay stable from req rise until ack.
REQ-009 Ack in the first ACCESS cycle SHALL be accepted (one cycle per memory op minimum); ack outside ACCESS SHALL be ignored.
REQ-010 stall_o SHALL equal (state==ACCESS && !dmem_ack_i), combinational.
REQ-011 Stores: SB (f3=000) replicate byte to all lanes, be=0001<<addr[1:0]; SH (001) replicate halfword, be=0011<<{addr[1],0}; SW (010) be=1111; dmem_addr_o SHALL be {addr[31:2],00}.
REQ-012 Loads SHALL select the lane by addr[1:0] and extend: LB 000 sign-ext, LH 001 sign-ext, LW 010, LBU 100 zero-ext, LHU 101 zero-ext; other f3 values -> result 0.
REQ-013 MEM/WB register SHALL capture on the edge where the EX/MEM entry completes (no mem op, or ack): memwb_wdata_o = extended load data for loads, else EX/MEM ALU value; when stall_o=1 it SHALL load a bubble (memwb_wb_reg_wr_o=0).
REQ-014 exmem_alu_o/exmem_rd_o SHALL reflect the EX/MEM register; exmem_wb_reg_wr_o SHALL be 0 while EX/MEM holds a load (address is not forwardable); load-use interlock belongs to the hazard unit.
REQ-015 rd=0 SHALL pass through unchanged (consumers ignore x0); stores SHALL never set memwb_wb_reg_wr_o.
REQ-016 Simultaneous ack and new EX op: current op retires to MEM/WB and new op enters EX/MEM on the same edge.

Reset
REQ-017 On rst: state IDLE; EX/MEM and MEM/WB cleared (all outputs 0); dmem_req_o=0 on the following cycle even mid-ACCESS; stall_o=0, misalign_o=0.
REQ-018 dmem_ack_i arriving after reset SHALL be ignored.

Configuration
REQ-019 Macro MEM_MISALIGN_TRAP_EN: defined -> halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL NOT issue a request, SHALL pulse misalign_o for 1 cycle, retire with wb suppressed.
REQ-020 Undefined -> misaligned low address bits SHALL be forced to alignment (word: [1:0]=0, half: [0]=0), access issued normally, misalign_o tied 0.

Verification
REQ-021 SW addr 0x104 data 0xDEADBEEF, ack after 2 cycles -> req 3 cycles, be=1111, stall_o=1 for 2 cycles, no register write.
REQ-022 LB addr 0x103, rdata 0x80112233, ack same cycle -> memwb_wdata_o=0xFFFFFF80, one-cycle access, no stall.
REQ-023 LHU addr 0x102, rdata 0x8001ABCD -> memwb_wdata_o=0x00008001; exmem_wb_reg_wr_o=0 while the load sits in EX/MEM.
REQ-024 ADD rd=5 result 7 followed by SB addr 0x2 data 0x55 -> exmem forward rd=5/7, then dmem_wdata_o=0x55555555, be=0100.
REQ-025 rst asserted mid-ACCESS -> dmem_req_o=0 next cycle, all outputs 0, late ack ignored.
REQ-026 LW addr 0x101: with MEM_MISALIGN_TRAP_EN -> misalign_o pulse, no req; without -> dmem_addr_o=0x100.
